vector_drain: RTL and testbench

VECTOR_DRAIN -- requirements
Module: vector_drain

---
 rtl/vector_pkg.sv | 19 +
 rtl/vd_next_lane.sv | 27 ++
 rtl/vector_drain.sv | 145 ++++++++++++++
 tb/tb_vector_drain.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// vector_pkg: shared defaults, FSM state encoding and lane-index type for vector_drain.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vector_pkg;

  localparam int LANES_DEF = 4;
  localparam int WIDTH_DEF = 32;
  localparam int AW_DEF    = 32;
  localparam int IDX_W     = $clog2(LANES_DEF);

  typedef logic [IDX_W-1:0] lane_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/vd_next_lane.sv
// vd_next_lane: priority encoder giving the lowest enabled lane strictly above cur_i.
// Latency: combinational.
// Backpressure: n/a; none_o=1 when no enabled lane remains above cur_i.
module vd_next_lane
  import vector_pkg::*;
#(
  parameter int LANES = LANES_DEF
) (
  input  logic [LANES-1:0] mask_i,
  input  lane_idx_t        cur_i,
  output lane_idx_t        nxt_o,
  output logic             none_o
);

  // Scan downward so the lowest qualifying lane is the last (winning) assignment.
  always_comb begin
    nxt_o  = '0;
    none_o = 1'b1;
    for (int i = LANES - 1; i >= 0; i--) begin
      if ((i > int'(cur_i)) && mask_i[i]) begin
        nxt_o  = lane_idx_t'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vector_drain.sv
// vector_drain: captures a LANES-element vector plus base address, then streams one
//   element per beat with address base+4*lane. Optional lane mask: VECTOR_DRAIN_MASK_EN.
// Latency: first beat the cycle after accept; one beat per cycle; done pulse after last beat.
// Backpressure: valid/ready on both sides; beats hold while out_ready=0; in_ready only in IDLE.
module vector_drain
  import vector_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  logic [WIDTH-1:0] data4,
  input  logic [AW-1:0]    base_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_addr,
  output logic             out_last,
  output logic             done
`ifdef VECTOR_DRAIN_MASK_EN
  ,
  input  logic [LANES-1:0] lane_mask
`endif
);

  state_e           state_q, state_d;
  lane_idx_t        idx_q, idx_d;
  logic [WIDTH-1:0] data_q [LANES];
  logic [WIDTH-1:0] vec_in [LANES];
  logic [AW-1:0]    base_q;
  logic             capture;
  lane_idx_t        first_idx;
  logic             first_none;
  lane_idx_t        nxt_idx;
  logic             last_lane;

  // Map the discrete data ports onto a lane-indexed array; lanes beyond the ports read zero.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      case (i)
        0:       vec_in[i] = data1;
        1:       vec_in[i] = data2;
        2:       vec_in[i] = data3;
        3:       vec_in[i] = data4;
        default: vec_in[i] = '0;
      endcase
    end
  end

`ifdef VECTOR_DRAIN_MASK_EN
  logic [LANES-1:0] mask_q;
  lane_idx_t        above0_idx;
  logic             above0_none;

  // Lane 0 is never "above" anything, so the first lane is lane 0 or the next one above it.
  vd_next_lane #(.LANES(LANES)) u_first (
    .mask_i (lane_mask),
    .cur_i  ('0),
    .nxt_o  (above0_idx),
    .none_o (above0_none)
  );

  vd_next_lane #(.LANES(LANES)) u_next (
    .mask_i (mask_q),
    .cur_i  (idx_q),
    .nxt_o  (nxt_idx),
    .none_o (last_lane)
  );

  assign first_idx  = lane_mask[0] ? '0 : above0_idx;
  assign first_none = !lane_mask[0] && above0_none;

  // Mask is captured together with the vector so later input changes cannot alter the walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mask_q <= '0;
    else if (capture) mask_q <= lane_mask;
  end
`else
  assign first_idx  = '0;
  assign first_none = 1'b0;
  assign nxt_idx    = idx_q + 1'b1;
  assign last_lane  = (idx_q == lane_idx_t'(LANES - 1));
`endif

  // State, lane index and captured vector registers; reset clears everything, even mid-stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      for (int i = 0; i < LANES; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        base_q <= base_addr;
        data_q <= vec_in;
      end
    end
  end

  // Next-state: accept in IDLE, walk enabled lanes on each handshake, one FIN cycle for done.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          idx_d   = first_idx;
          state_d = first_none ? FIN : SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_lane) begin
            state_d = FIN;
            idx_d   = '0;
          end else begin
            idx_d = nxt_idx;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rst_n gates in_ready so it reads low while reset is held, not just after the first edge.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == SEND);
  assign out_last  = out_valid && last_lane;
  assign done      = (state_q == FIN);
  assign out_data  = data_q[idx_q];
  assign out_addr  = base_q + (AW'(idx_q) << 2);

endmodule

// File: tb/tb_vector_drain.sv
// tb_vector_drain: scoreboard bench for vector_drain (default build, or with VECTOR_DRAIN_MASK_EN).
// Latency: expected beat cycles are checked when strict timing is enabled.
// Backpressure: exercises stalls and random out_ready.
module tb_vector_drain;

  localparam int LANES = 4;
  localparam int WIDTH = 32;
  localparam int AW    = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] data1 = '0, data2 = '0, data3 = '0, data4 = '0;
  logic [AW-1:0]    base_addr = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_addr;
  logic             out_last;
  logic             done;
`ifdef VECTOR_DRAIN_MASK_EN
  logic [LANES-1:0] lane_mask = '1;
`endif

  vector_drain #(.LANES(LANES), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .data4     (data4),
    .base_addr (base_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .done      (done)
`ifdef VECTOR_DRAIN_MASK_EN
    ,
    .lane_mask (lane_mask)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [31:0] a;
    logic        l;
    int          c;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          exp_done = -1;
  int          last_beat_cyc = -100;
  bit          strict = 1'b0;
  bit          t6_chk = 1'b0;
  logic [31:0] dv [4];
  logic [3:0]  m;
  int          nen;
  int          j;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pop/compare beats, track done timing, and push expectations on every accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("beat_unexpected", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("beat_data", out_data, mon_e.d);
          check("beat_addr", out_addr, mon_e.a);
          check("beat_last", out_last, mon_e.l);
          if (mon_e.c >= 0) check("beat_cycle", cyc, mon_e.c);
          if (mon_e.l) begin
            last_beat_cyc = cyc;
            exp_done      = cyc + 1;
          end
        end
      end
      if (exp_done >= 0 && cyc == exp_done) begin
        check("done_pulse", done, 1);
        check("in_ready_in_fin", in_ready, 0);
        exp_done = -1;
      end else if (done) begin
        check("done_spurious", 1, 0);
      end
      if (in_valid && in_ready) begin
        dv[0] = data1; dv[1] = data2; dv[2] = data3; dv[3] = data4;
`ifdef VECTOR_DRAIN_MASK_EN
        m = lane_mask;
`else
        m = 4'hF;
`endif
        nen = $countones(m);
        j   = 0;
        for (int l = 0; l < 4; l++) begin
          if (m[l]) begin
            mon_e.d = dv[l];
            mon_e.a = base_addr + 32'(4 * l);
            mon_e.l = (j == nen - 1);
            mon_e.c = strict ? (cyc + 1 + j) : -1;
            sb.push_back(mon_e);
            j++;
          end
        end
        if (nen == 0) exp_done = cyc + 1;
        if (t6_chk) begin
          check("t6_second_accept_cycle", cyc + 1, last_beat_cyc + 3);
          t6_chk = 1'b0;
        end
      end
    end
  end

  task automatic set_vec(input logic [31:0] a, b, c, d, input logic [31:0] base, input logic [3:0] msk);
    data1 = a; data2 = b; data3 = c; data4 = d; base_addr = base;
`ifdef VECTOR_DRAIN_MASK_EN
    lane_mask = msk;
`else
    if (msk != 4'hF) check("mask_unsupported", 0, 1);
`endif
  endtask

  task automatic scramble();
    data1 = $urandom; data2 = $urandom; data3 = $urandom; data4 = $urandom; base_addr = $urandom;
`ifdef VECTOR_DRAIN_MASK_EN
    lane_mask = 4'($urandom);
`endif
  endtask

  task automatic send_vec(input logic [31:0] a, b, c, d, input logic [31:0] base, input logic [3:0] msk);
    int n;
    @(posedge clk); #1;
    set_vec(a, b, c, d, base, msk);
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (n >= 100) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    while ((sb.size() != 0 || exp_done >= 0) && n < 300) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom % 2) : 1'b1;
      n++;
    end
    check("drain_timeout", (n < 300), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_out_data(input logic [31:0] v);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(out_valid && out_data == v) && n < 100);
    if (n >= 100) check("wait_beat_timeout", 0, 1);
  endtask

  initial begin
    int n;
    // Reset state
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);

    // Test 1: basic stream, back-to-back beats
    strict = 1'b1;
    send_vec(32'd1, 32'd2, 32'd3, 32'd4, 32'h100, 4'hF);
    wait_idle(1'b0);

    // Test 2: stall on beat 2 for three cycles
    strict = 1'b0;
    send_vec(32'd10, 32'd20, 32'd30, 32'd40, 32'h100, 4'hF);
    wait_out_data(32'd20);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 32'd20);
      check("stall_addr", out_addr, 32'h104);
      check("stall_last", out_last, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle(1'b0);

    // Test 3: address wrap
    strict = 1'b1;
    send_vec(32'd5, 32'd6, 32'd7, 32'd8, 32'hFFFF_FFF8, 4'hF);
    wait_idle(1'b0);

    // Test 4: asynchronous reset during beat 3
    strict = 1'b0;
    send_vec(32'd51, 32'd52, 32'd53, 32'd54, 32'h240, 4'hF);
    wait_out_data(32'd53);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_addr", out_addr, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_done", done, 0);
    sb.delete();
    exp_done = -1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("arst_rel_in_ready", in_ready, 1);
    strict = 1'b1;
    send_vec(32'd31, 32'd32, 32'd33, 32'd34, 32'h500, 4'hF);
    wait_idle(1'b0);

`ifdef VECTOR_DRAIN_MASK_EN
    // Test 5: sparse and empty masks
    send_vec(32'd61, 32'd62, 32'd63, 32'd64, 32'h200, 4'b1010);
    wait_idle(1'b0);
    send_vec(32'd71, 32'd72, 32'd73, 32'd74, 32'h200, 4'b0000);
    wait_idle(1'b0);
    send_vec(32'd81, 32'd82, 32'd83, 32'd84, 32'h200, 4'b0001);
    wait_idle(1'b0);
`endif

    // Test 6: in_valid held high with new data during SEND
    @(posedge clk); #1;
    set_vec(32'd11, 32'd12, 32'd13, 32'd14, 32'h300, 4'hF);
    in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    @(posedge clk); #1;
    set_vec(32'd21, 32'd22, 32'd23, 32'd24, 32'h400, 4'hF);
    t6_chk = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    if (n >= 100) check("t6_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    wait_idle(1'b0);
    check("t6_second_accept_seen", t6_chk, 0);

    // Random backpressure over a few vectors
    strict = 1'b0;
    for (int v = 0; v < 4; v++) begin
      send_vec($urandom, $urandom, $urandom, $urandom, $urandom, 4'hF);
      wait_idle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
